// File: rtl/vscale_htif_pcr_arbiter_pkg.sv
// Shared types and constants for the HTIF PCR port arbiter: FSM encoding,
// PCR/CSR widths and the round-robin pointer wrap helper.
package vscale_htif_pcr_arbiter_pkg;

  localparam int HTIF_PCR_WIDTH = 64;
  localparam int CSR_ADDR_WIDTH = 12;
  localparam int ARB_STATE_W    = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_RESP = 2'd2,
    ARB_DELIVER   = 2'd3
  } arb_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vscale_htif_pcr_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping modulo N. The pointer register lives in the parent.
module vscale_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_grant_o
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_rot;
  int             pos;
  int             idx_sum;

  always_comb begin
    // Rotating a doubled copy puts the pointer position at bit 0.
    req_dbl     = {req_i, req_i};
    req_rot     = req_dbl >> ptr_i;
    any_grant_o = 1'b0;
    pos         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any_grant_o = 1'b1;
        pos         = k;
      end
    end
    idx_sum = int'(ptr_i) + pos;
    if (idx_sum >= N) idx_sum = idx_sum - N;
    grant_idx_o = IDX_W'(idx_sum);
    grant_o     = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = any_grant_o && (grant_idx_o == IDX_W'(i));
    end
  end

endmodule

// File: rtl/vscale_htif_pcr_arbiter.sv
// Shares the core's single HTIF PCR port among N_REQ host requesters with
// round-robin grant and one transaction in flight at a time.
module vscale_htif_pcr_arbiter
  import vscale_htif_pcr_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = HTIF_PCR_WIDTH,
  parameter int ADDR_WIDTH = CSR_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_rw,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            resp_valid,
  input  logic [N_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]       resp_data,
  output logic                        pcr_req_valid,
  input  logic                        pcr_req_ready,
  output logic                        pcr_req_rw,
  output logic [ADDR_WIDTH-1:0]       pcr_req_addr,
  output logic [DATA_WIDTH-1:0]       pcr_req_data,
  input  logic                        pcr_resp_valid,
  output logic                        pcr_resp_ready,
  input  logic [DATA_WIDTH-1:0]       pcr_resp_data,
  output logic                        busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic                    rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [N_REQ-1:0]        grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    any_grant;
  logic                    sel_rw;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [N_REQ-1:0]        owner_oh;
  logic                    owner_resp_ready;

  vscale_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (rr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  always_comb begin
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    owner_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_rw   = req_rw[i];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      owner_oh[i] = (owner_q == IDX_W'(i));
    end
    // Only the owner's resp_ready can retire a delivered response.
    owner_resp_ready = |(owner_oh & resp_ready);
  end

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    owner_d        = owner_q;
    rw_d           = rw_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    req_ready      = '0;
    resp_valid     = '0;
    pcr_req_valid  = 1'b0;
    pcr_resp_ready = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // Gated by reset_n so nothing is offered while reset is asserted.
        req_ready = grant & {N_REQ{reset_n}};
        if (any_grant) begin
          owner_d = grant_idx;
          rr_d    = IDX_W'(rr_next(int'(grant_idx), N_REQ));
          rw_d    = sel_rw;
          addr_d  = sel_addr;
          wdata_d = sel_data;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        pcr_req_valid = 1'b1;
        if (pcr_req_ready) state_d = ARB_WAIT_RESP;
      end
      ARB_WAIT_RESP: begin
        pcr_resp_ready = 1'b1;
        if (pcr_resp_valid) begin
          rdata_d = pcr_resp_data;
          state_d = ARB_DELIVER;
        end
      end
      ARB_DELIVER: begin
        resp_valid = owner_oh;
        if (owner_resp_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign pcr_req_rw   = rw_q;
  assign pcr_req_addr = addr_q;
  assign pcr_req_data = wdata_q;
  assign resp_data    = rdata_q;
  assign busy         = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Self-checking bench for vscale_htif_pcr_arbiter (N_REQ = 3): directed
// scenarios plus randomized transactions against a round-robin reference model.
module tb_vscale_htif_pcr_arbiter;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int AW = 12;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_rw;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [DW-1:0]   resp_data;
  logic            pcr_req_valid;
  logic            pcr_req_ready;
  logic            pcr_req_rw;
  logic [AW-1:0]   pcr_req_addr;
  logic [DW-1:0]   pcr_req_data;
  logic            pcr_resp_valid;
  logic            pcr_resp_ready;
  logic [DW-1:0]   pcr_resp_data;
  logic            busy;

  int total;
  int passed;
  int failed;
  int rr_m;
  int g;

  vscale_htif_pcr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .pcr_req_valid  (pcr_req_valid),
    .pcr_req_ready  (pcr_req_ready),
    .pcr_req_rw     (pcr_req_rw),
    .pcr_req_addr   (pcr_req_addr),
    .pcr_req_data   (pcr_req_data),
    .pcr_resp_valid (pcr_resp_valid),
    .pcr_resp_ready (pcr_resp_ready),
    .pcr_resp_data  (pcr_resp_data),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic rw,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_rw[i]              = rw;
    req_addr[i*AW +: AW]   = a;
    req_data[i*DW +: DW]   = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rr_m    = 0;
  endtask

  // One full transaction starting in IDLE just after a rising edge. The expected
  // grant is the first valid requester at or after the model pointer.
  task automatic run_txn(input int stall, input int bp, input logic [DW-1:0] rdata,
                         input bit noise, output int gi);
    logic [N-1:0]  oh;
    logic          erw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    gi  = -1;
    oh  = '0;
    erw = 1'b0;
    ea  = '0;
    ed  = '0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (gi < 0 && req_valid[(rr_m + k) % N]) gi = (rr_m + k) % N;
    end
    if (gi >= 0) begin
      oh[gi] = 1'b1;
      erw    = req_rw[gi];
      ea     = req_addr[gi*AW +: AW];
      ed     = req_data[gi*DW +: DW];
    end
    chk("req_ready_grant", 64'(req_ready), 64'(oh));
    @(posedge clk); #1;
    if (gi < 0) return;
    rr_m          = (gi + 1) % N;
    req_valid[gi] = 1'b0;
    if (noise) req_valid = N'($urandom) | ~oh;
    for (int c = 0; c <= stall; c++) begin
      if (c == stall) pcr_req_ready = 1'b1;
      @(negedge clk);
      chk("pcr_req_valid", 64'(pcr_req_valid), 64'(1));
      chk("pcr_req_rw", 64'(pcr_req_rw), 64'(erw));
      chk("pcr_req_addr", 64'(pcr_req_addr), 64'(ea));
      chk("pcr_req_data", pcr_req_data, ed);
      chk("issue_req_ready", 64'(req_ready), 64'(0));
      chk("issue_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
    end
    pcr_req_ready  = 1'b0;
    pcr_resp_valid = 1'b1;
    pcr_resp_data  = rdata;
    @(negedge clk);
    chk("wait_pcr_resp_ready", 64'(pcr_resp_ready), 64'(1));
    chk("wait_pcr_req_valid", 64'(pcr_req_valid), 64'(0));
    chk("wait_resp_valid", 64'(resp_valid), 64'(0));
    @(posedge clk); #1;
    pcr_resp_valid = 1'b0;
    pcr_resp_data  = {$urandom, $urandom};
    resp_ready     = ~oh;
    for (int c = 0; c <= bp; c++) begin
      if (c == bp) resp_ready = '1;
      @(negedge clk);
      chk("deliver_resp_valid", 64'(resp_valid), 64'(oh));
      chk("deliver_resp_data", resp_data, rdata);
      chk("deliver_req_ready", 64'(req_ready), 64'(0));
      chk("deliver_pcr_req_valid", 64'(pcr_req_valid), 64'(0));
      chk("deliver_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
    end
    resp_ready = '0;
    if (noise) req_valid = '0;
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_resp_valid", 64'(resp_valid), 64'(0));
  endtask

  initial begin
    total          = 0;
    passed         = 0;
    failed         = 0;
    rr_m           = 0;
    reset_n        = 1'b0;
    req_valid      = '1;
    req_rw         = '0;
    req_addr       = '0;
    req_data       = '0;
    resp_ready     = '1;
    pcr_req_ready  = 1'b1;
    pcr_resp_valid = 1'b1;
    pcr_resp_data  = 64'h5;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", resp_data, 64'(0));
    chk("rst_pcr_req_valid", 64'(pcr_req_valid), 64'(0));
    chk("rst_pcr_resp_ready", 64'(pcr_resp_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    req_valid      = '0;
    resp_ready     = '0;
    pcr_req_ready  = 1'b0;
    pcr_resp_valid = 1'b0;
    pcr_resp_data  = '0;
    do_reset();

    // Single read with a 2-cycle stall on pcr_req_ready.
    set_req(0, 1'b1, 1'b0, 12'h780, 64'h0);
    run_txn(2, 0, 64'h1, 1'b0, g);
    chk("single_grant", 64'(g), 64'(0));

    // Contention from reset: 0 reads 0x780, 1 writes 0xDEAD to 0x781.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      set_req(0, 1'b1, 1'b0, 12'h780, 64'h0);
      set_req(1, 1'b1, 1'b1, 12'h781, 64'hDEAD);
      run_txn(0, 0, {$urandom, $urandom}, 1'b0, g);
      chk("contention_order", 64'(g), 64'(t % 2));
    end
    req_valid = '0;

    // Backpressure on requester 1 with other requesters clamouring.
    set_req(1, 1'b1, 1'b0, 12'h7C0, 64'h0);
    set_req(0, 1'b0, 1'b0, 12'h123, 64'h0);
    rr_m = 0;
    do_reset();
    set_req(1, 1'b1, 1'b0, 12'h7C0, 64'h0);
    run_txn(1, 10, 64'hCAFE_F00D_1234_5678, 1'b1, g);
    chk("bp_grant", 64'(g), 64'(1));

    // Async reset in WAIT_RESP; late core response must be dropped.
    set_req(1, 1'b1, 1'b0, 12'h7A0, 64'h0);
    @(negedge clk);
    chk("ar_grant", 64'(req_ready), 64'(3'b010));
    @(posedge clk); #1;
    req_valid     = '0;
    pcr_req_ready = 1'b1;
    @(posedge clk); #1;
    pcr_req_ready = 1'b0;
    @(negedge clk);
    chk("ar_wait", 64'(pcr_resp_ready), 64'(1));
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_pcr_resp_ready", 64'(pcr_resp_ready), 64'(0));
    chk("ar_pcr_req_valid", 64'(pcr_req_valid), 64'(0));
    chk("ar_resp_valid", 64'(resp_valid), 64'(0));
    @(posedge clk); #1;
    reset_n        = 1'b1;
    rr_m           = 0;
    pcr_resp_valid = 1'b1;
    pcr_resp_data  = 64'h5;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("ar_late_resp_valid", 64'(resp_valid), 64'(0));
      chk("ar_late_pcr_resp_ready", 64'(pcr_resp_ready), 64'(0));
      chk("ar_late_resp_data", resp_data, 64'(0));
      @(posedge clk); #1;
    end
    pcr_resp_valid = 1'b0;
    set_req(0, 1'b1, 1'b1, 12'h701, 64'h77);
    set_req(1, 1'b1, 1'b0, 12'h702, 64'h0);
    run_txn(0, 0, 64'h99, 1'b0, g);
    chk("ar_next_grant", 64'(g), 64'(0));
    req_valid = '0;

    // Spurious core response while idle.
    for (int c = 0; c < 3; c++) begin
      pcr_resp_valid = 1'b1;
      pcr_resp_data  = {$urandom, $urandom};
      @(negedge clk);
      chk("spur_resp_valid", 64'(resp_valid), 64'(0));
      chk("spur_pcr_resp_ready", 64'(pcr_resp_ready), 64'(0));
      chk("spur_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
    end
    pcr_resp_valid = 1'b0;
    @(negedge clk);
    chk("spur_after_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;

    // Wrap: only 2 first, then 0 and 1 together.
    do_reset();
    set_req(2, 1'b1, 1'b1, 12'h7F2, 64'h2222);
    run_txn(0, 0, 64'hA2, 1'b0, g);
    chk("wrap_first", 64'(g), 64'(2));
    set_req(0, 1'b1, 1'b0, 12'h7F0, 64'h0);
    set_req(1, 1'b1, 1'b1, 12'h7F1, 64'h1111);
    run_txn(0, 0, 64'hA0, 1'b0, g);
    chk("wrap_second", 64'(g), 64'(0));
    run_txn(0, 0, 64'hA1, 1'b0, g);
    chk("wrap_third", 64'(g), 64'(1));
    req_valid = '0;

    // Randomized transactions against the round-robin model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom), {$urandom, $urandom});
      end
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              {$urandom, $urandom}, 1'b0, g);
      req_valid = '0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vscale_htif_pcr_arbiter.md
Name: vscale_htif_pcr_arbiter

Overview:
- Shares the core's single HTIF PCR request/response port among N_REQ host-side requesters, e.g. a tohost poller, a fromhost writer and a debug CSR reader.
- Round-robin grant; exactly one transaction outstanding at a time.
- Response data is captured into a holding register and returned only to the requester that issued the transaction.
- Sits between the test harness / host glue and vscale_top's htif_pcr_* ports.

Parameters:
- N_REQ, 2, number of requester ports (2..8)
- DATA_WIDTH, 64, PCR data width (equals HTIF_PCR_WIDTH)
- ADDR_WIDTH, 12, CSR address width

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester request accepted
- req_rw  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_WIDTH  flattened CSR addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  N_REQ*DATA_WIDTH  flattened write data
- resp_valid  out  N_REQ  one-hot response valid
- resp_ready  in  N_REQ  per-requester response accept
- resp_data  out  DATA_WIDTH  response data, shared by all requesters, qualified by resp_valid
- pcr_req_valid / pcr_req_ready / pcr_req_rw / pcr_req_addr / pcr_req_data  out/in/out/out/out  1/1/1/ADDR_WIDTH/DATA_WIDTH  request to core
- pcr_resp_valid / pcr_resp_ready / pcr_resp_data  in/out/in  1/1/DATA_WIDTH  response from core
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT_RESP, DELIVER.
- Reset (async, reset_n = 0), effective immediately:
  - state = IDLE, rr pointer = 0, owner = 0.
  - Captured request and response registers cleared.
  - Outputs: req_ready = 0, resp_valid = 0, resp_data = 0, pcr_req_valid = 0, pcr_resp_ready = 0, busy = 0.
- Reset mid-transaction drops the transaction silently; a core response arriving after reset release is ignored in IDLE (pcr_resp_ready = 0 there).
- IDLE:
  - Grant = first asserted req_valid at or after the rr pointer, wrapping modulo N_REQ.
  - req_ready[grant] = 1 combinationally in the same cycle; all other req_ready = 0.
  - On handshake: latch rw, addr and data into the request register; owner = grant; rr pointer = grant + 1 mod N_REQ; go to ISSUE.
- ISSUE:
  - pcr_req_valid = 1, driven from registers; rw/addr/data held stable until pcr_req_ready.
  - On pcr_req_ready = 1: go to WAIT_RESP.
- WAIT_RESP:
  - pcr_resp_ready = 1.
  - On pcr_resp_valid: latch pcr_resp_data into the response register; go to DELIVER.
  - Writes also wait for a response (the core acknowledges every request).
- DELIVER:
  - resp_valid[owner] = 1; resp_data = response register.
  - Held until resp_ready[owner] = 1, then go to IDLE.
- Minimum latency: request accept -> resp_valid in 3 cycles, with pcr_req_ready and pcr_resp_valid both already high.
- No new grant before return to IDLE, so back-to-back transactions are spaced at least 4 cycles apart.
- resp_ready of non-owners is ignored. req_valid may drop while not granted; no state is kept for ungranted requests.
- Simultaneous requests: rr order only. Starvation bound is N_REQ-1 transactions.
- pcr_resp_valid outside WAIT_RESP is ignored.

Decomposition:
- Shared header vscale_htif_arb_constants.vh holds:
  - FSM state width and encodings (IDLE = 0, ISSUE = 1, WAIT_RESP = 2, DELIVER = 3).
  - Reuse of HTIF_PCR_WIDTH and CSR address width from the existing control/CSR headers.
- One sub-module: vscale_rr_arbiter (N parameter; inputs req vector, pointer; outputs one-hot grant, grant index, any_grant). It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Single read: req 0 reads addr 0x780; core returns 0x1 after a 2-cycle stall on pcr_req_ready -> pcr_req_addr = 0x780, pcr_req_rw = 0, then resp_valid = 2'b01 with resp_data = 0x1; busy falls the cycle after resp_ready.
- Contention: both requesters valid every cycle from reset (req 0 reads 0x780, req 1 writes 0xDEAD to 0x781) -> grants alternate 0,1,0,1; every response is routed to the matching requester.
- Backpressure: hold resp_ready[1] = 0 for 10 cycles in DELIVER -> resp_valid[1] and resp_data stay stable, req_ready = 0 throughout, and no new pcr_req_valid is issued.
- Async reset in WAIT_RESP: reset_n low mid-cycle -> outputs clear immediately; a core response 0x5 arriving after release is not forwarded; the next request is granted to requester 0.
- Spurious core response: pcr_resp_valid pulsed while in IDLE -> no resp_valid, pcr_resp_ready = 0, state unchanged.
- Wrap with N_REQ = 3: only req 2 active, then req 0 and req 1 both active -> grant order 2, 0, 1.
